// File: rtl/training_sample_sequencer.sv
// Training-set buffer that replays stored (x, desired_y) samples for a
// programmable number of epochs, holding each sample for HOLD_CYCLES clocks.
//
//   state   | meaning
//   IDLE    | buffer load / clear allowed, outputs zero
//   PRESENT | replaying samples, one every HOLD_CYCLES clocks
//   DONE    | single-cycle completion pulse, then back to IDLE
module training_sample_sequencer #(
    parameter int DW          = 9,
    parameter int DEPTH       = 256,
    parameter int AW          = 8,
    parameter int HOLD_CYCLES = 24
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 wr_en,
    input  logic [6*DW-1:0]      wr_data,
    output logic                 wr_ready,
    input  logic                 clr,
    input  logic                 start,
    input  logic                 abort,
    input  logic [7:0]           num_epochs,
    output logic signed [DW-1:0] x0,
    output logic signed [DW-1:0] x1,
    output logic signed [DW-1:0] x2,
    output logic signed [DW-1:0] x3,
    output logic signed [DW-1:0] desired_y0,
    output logic signed [DW-1:0] desired_y1,
    output logic                 sample_strobe,
    output logic                 sample_valid,
    output logic [AW-1:0]        sample_idx,
    output logic [7:0]           epoch_idx,
    output logic                 busy,
    output logic                 done,
    output logic [AW:0]          count
);

    localparam int          HW   = $clog2(HOLD_CYCLES);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, PRESENT, DONE} state_t;

    state_t            state, state_next;
    logic [6*DW-1:0]   mem [DEPTH];
    logic [6*DW-1:0]   data_q;
    logic [HW-1:0]     hold_cnt;
    logic [7:0]        epochs_lat;

    logic do_write, do_clr, go_present, advance, leave_present;
    logic last_hold, last_sample, last_epoch;

    assign last_hold   = (hold_cnt == HW'(HOLD_CYCLES - 1));
    assign last_sample = ({1'b0, sample_idx} == (count - (AW+1)'(1)));
    assign last_epoch  = (epoch_idx == (epochs_lat - 8'd1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next    = state;
        wr_ready      = 1'b0;
        do_write      = 1'b0;
        do_clr        = 1'b0;
        go_present    = 1'b0;
        advance       = 1'b0;
        leave_present = 1'b0;
        case (state)
            IDLE: begin
                wr_ready = (count != FULL) & !start & !clr;
                if (start) begin
                    if (count == '0 || num_epochs == 8'd0) begin
                        state_next = DONE;
                    end else begin
                        state_next = PRESENT;
                        go_present = 1'b1;
                    end
                end else if (clr) begin
                    do_clr = 1'b1;
                end else if (wr_en && wr_ready) begin
                    do_write = 1'b1;
                end
            end
            PRESENT: begin
                if (abort) begin
                    state_next    = IDLE;
                    leave_present = 1'b1;
                end else if (last_hold) begin
                    if (last_sample && last_epoch) begin
                        state_next    = DONE;
                        leave_present = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Buffer has no reset; entries beyond count are never read.
    always_ff @(posedge CLK) begin
        if (do_write) mem[count[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count         <= '0;
            data_q        <= '0;
            sample_idx    <= '0;
            epoch_idx     <= '0;
            hold_cnt      <= '0;
            epochs_lat    <= '0;
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= 1'b0;
            if (do_clr)   count <= '0;
            if (do_write) count <= count + (AW+1)'(1);
            if (go_present) begin
                data_q        <= mem[0];
                sample_idx    <= '0;
                epoch_idx     <= '0;
                hold_cnt      <= '0;
                epochs_lat    <= num_epochs;
                sample_strobe <= 1'b1;
            end else if (leave_present) begin
                data_q     <= '0;
                sample_idx <= '0;
                epoch_idx  <= '0;
                hold_cnt   <= '0;
            end else if (advance) begin
                hold_cnt      <= '0;
                sample_strobe <= 1'b1;
                if (last_sample) begin
                    sample_idx <= '0;
                    epoch_idx  <= epoch_idx + 8'd1;
                    data_q     <= mem[0];
                end else begin
                    sample_idx <= sample_idx + AW'(1);
                    data_q     <= mem[sample_idx + AW'(1)];
                end
            end else if (state == PRESENT) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

    assign x0           = data_q[6*DW-1 -: DW];
    assign x1           = data_q[5*DW-1 -: DW];
    assign x2           = data_q[4*DW-1 -: DW];
    assign x3           = data_q[3*DW-1 -: DW];
    assign desired_y0   = data_q[2*DW-1 -: DW];
    assign desired_y1   = data_q[DW-1 -: DW];
    assign sample_valid = (state == PRESENT);
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);

endmodule

// File: tb/tb_training_sample_sequencer.sv
// Directed bench for training_sample_sequencer with a scoreboard of expected
// presented samples (index, epoch, packed fields).
module tb_training_sample_sequencer;

    localparam int DW = 9, DEPTH = 256, AW = 8, HOLD = 24;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b0;
    logic                 wr_en = 1'b0, clr = 1'b0, start = 1'b0, abort = 1'b0;
    logic [6*DW-1:0]      wr_data = '0;
    logic [7:0]           num_epochs = '0;
    logic                 wr_ready, sample_strobe, sample_valid, busy, done;
    logic signed [DW-1:0] x0, x1, x2, x3, desired_y0, desired_y1;
    logic [AW-1:0]        sample_idx;
    logic [7:0]           epoch_idx;
    logic [AW:0]          count;

    typedef struct {
        logic [7:0]      idx;
        logic [7:0]      epoch;
        logic [6*DW-1:0] data;
    } exp_t;

    exp_t            sb[$];
    logic [6*DW-1:0] model[$];
    int              checks = 0;
    int              errors = 0;

    training_sample_sequencer #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .HOLD_CYCLES(HOLD)) dut (
        .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
        .clr(clr), .start(start), .abort(abort), .num_epochs(num_epochs),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .desired_y0(desired_y0), .desired_y1(desired_y1),
        .sample_strobe(sample_strobe), .sample_valid(sample_valid), .sample_idx(sample_idx),
        .epoch_idx(epoch_idx), .busy(busy), .done(done), .count(count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6*DW-1:0] pack(input int a, b, c, d, e, f);
        logic [DW-1:0] fa = DW'(a), fb = DW'(b), fc = DW'(c);
        logic [DW-1:0] fd = DW'(d), fe = DW'(e), ff = DW'(f);
        return {fa, fb, fc, fd, fe, ff};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; write spans exactly one rising edge.
    task automatic write_sample(input logic [6*DW-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge CLK);
        wr_en   = 1'b0;
        if (model.size() < DEPTH) model.push_back(d);
    endtask

    task automatic pulse_start(input logic [7:0] ep);
        num_epochs = ep;
        start      = 1'b1;
        @(posedge CLK);
        #1 start   = 1'b0;
    endtask

    task automatic push_expected(input int epochs);
        for (int e = 0; e < epochs; e++)
            for (int i = 0; i < model.size(); i++)
                sb.push_back('{idx: 8'(i), epoch: 8'(e), data: model[i]});
    endtask

    task automatic run_replay(input int max_cycles, input int exp_present);
        int   cyc = 0, first = -1, last = -1;
        bit   got_done = 0;
        exp_t e;
        while (cyc < max_cycles && !got_done) begin
            @(negedge CLK);
            cyc++;
            if (sample_strobe) begin
                if (sb.size() == 0) begin
                    chk("extra_strobe", 64'(sample_idx), 64'hFFFF);
                end else begin
                    e = sb.pop_front();
                    chk("sample_idx", 64'(sample_idx), 64'(e.idx));
                    chk("epoch_idx", 64'(epoch_idx), 64'(e.epoch));
                    chk("fields", 64'({x0, x1, x2, x3, desired_y0, desired_y1}), 64'(e.data));
                    if (last >= 0) chk("strobe_gap", 64'(cyc - last), 64'(HOLD));
                    else           chk("first_latency", 64'(cyc), 64'd1);
                    if (first < 0) first = cyc;
                    last = cyc;
                end
            end
            if (done) begin
                got_done = 1;
                chk("done_time", 64'(cyc - first), 64'(exp_present));
                chk("done_valid", 64'(sample_valid), 64'd0);
                chk("done_data", 64'(x0), 64'd0);
            end
        end
        if (!got_done) chk("done_timeout", 64'd0, 64'd1);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        sb.delete();
        @(negedge CLK);
        chk("idle_after_done", 64'({busy, done}), 64'd0);
    endtask

    task automatic expect_immediate_done(input string tag);
        @(negedge CLK);
        chk({tag, "_done"}, 64'({done, sample_strobe, busy}), 64'b101);
        @(negedge CLK);
        chk({tag, "_idle"}, 64'({done, busy}), 64'd0);
    endtask

    task automatic wait_strobe_idx(input logic [AW-1:0] target, input string tag);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(sample_strobe && sample_idx == target) && n < 200);
        if (n >= 200) chk({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_flags", 64'({busy, done, sample_valid, sample_strobe}), 64'd0);
        chk("rst_data", 64'({x0, x1, x2, x3, desired_y0, desired_y1}), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("idle_wr_ready", 64'(wr_ready), 64'd1);

        // asynchronous reset during replay
        write_sample(pack(11, 12, 13, 14, 15, 16));
        write_sample(pack(21, 22, 23, 24, 25, 26));
        write_sample(pack(31, 32, 33, 34, 35, 36));
        pulse_start(8'd1);
        wait_strobe_idx(AW'(1), "rst_wait");
        chk("pre_rst_x0", 64'(x0), 64'(DW'(21)));
        #3 RST = 1'b0;
        #1;
        chk("async_rst_data", 64'({x0, desired_y1}), 64'd0);
        chk("async_rst_flags", 64'({sample_valid, busy, done}), 64'd0);
        chk("async_rst_count", 64'(count), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        model.delete();
        @(negedge CLK);
        chk("post_rst_idle", 64'({busy, wr_ready}), 64'b01);

        // load and replay two epochs of three samples
        write_sample(pack(1, -2, 3, -4, 5, -6));
        write_sample(pack(7, 8, 9, 10, -1, 1));
        write_sample(pack(-256, 255, 0, 0, 1, 0));
        chk("count_3", 64'(count), 64'd3);
        push_expected(2);
        pulse_start(8'd2);
        run_replay(400, 3 * 2 * HOLD);

        // abort in epoch 0, sample 1
        pulse_start(8'd1);
        wait_strobe_idx(AW'(1), "abort_wait");
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        chk("abort_flags", 64'({sample_valid, busy, done}), 64'd0);
        chk("abort_data", 64'(x0), 64'd0);
        chk("abort_count", 64'(count), 64'd3);
        @(negedge CLK);
        chk("abort_no_done", 64'(done), 64'd0);
        push_expected(1);
        pulse_start(8'd1);
        run_replay(200, 3 * HOLD);

        // start + wr_en with zero epochs: write dropped, immediate done
        wr_en   = 1'b1;
        wr_data = pack(99, 99, 99, 99, 99, 99);
        num_epochs = 8'd0;
        start   = 1'b1;
        @(negedge CLK);
        wr_en   = 1'b0;
        start   = 1'b0;
        chk("start_wr_done", 64'({done, sample_strobe}), 64'b10);
        chk("start_wr_count", 64'(count), 64'd3);
        @(negedge CLK);

        // clr + wr_en clears, then start on empty buffer
        wr_en = 1'b1;
        clr   = 1'b1;
        @(negedge CLK);
        wr_en = 1'b0;
        clr   = 1'b0;
        model.delete();
        chk("clr_count", 64'(count), 64'd0);
        num_epochs = 8'd3;
        start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        expect_immediate_done("empty");

        // count=2, zero epochs
        write_sample(pack(-1, -1, -1, -1, -1, -1));
        write_sample(pack(100, -100, 50, -50, 0, 1));
        pulse_start(8'd0);
        expect_immediate_done("zero_ep");

        // writes during PRESENT are ignored
        push_expected(1);
        pulse_start(8'd1);
        fork
            run_replay(200, 2 * HOLD);
            begin
                repeat (5) @(negedge CLK);
                wr_en = 1'b1;
                wr_data = pack(5, 5, 5, 5, 5, 5);
                @(negedge CLK);
                chk("present_wr_ready", 64'(wr_ready), 64'd0);
                wr_en = 1'b0;
            end
        join
        chk("present_wr_count", 64'(count), 64'd2);

        // full buffer: 257 writes, 256 stored, one-epoch replay
        clr = 1'b1;
        @(negedge CLK);
        clr = 1'b0;
        model.delete();
        for (int i = 0; i < DEPTH; i++)
            write_sample(54'({$urandom, $urandom}));
        chk("full_count", 64'(count), 64'(DEPTH));
        chk("full_wr_ready", 64'(wr_ready), 64'd0);
        write_sample(pack(1, 1, 1, 1, 1, 1));
        chk("overflow_count", 64'(count), 64'(DEPTH));
        push_expected(1);
        pulse_start(8'd1);
        run_replay(DEPTH * HOLD + 50, DEPTH * HOLD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
